// File: rtl/dds_symbol_sequencer.sv
// Symbol-rate sequencer for the DDS modulator: latches a payload/mode and plays it out MSB first.
// Optional `DDS_SEQ_IDLE_CARRIER_EN keeps dds_en high while idle so the carrier keeps running.
module dds_symbol_sequencer #(
  parameter int FREQ_CLK = 50_000_000,
  parameter int BAUD     = 1,
  parameter int WORD_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  input  logic [2:0]        in_mode,
  output logic [2:0]        dds_mode,
  output logic [1:0]        dds_data,
  output logic              dds_en,
  output logic              sym_tick,
  output logic              busy,
  output logic              done
);

  localparam int BAUD_DIV = FREQ_CLK / BAUD;
  localparam int BCW      = $clog2(BAUD_DIV);
  localparam int SCW      = $clog2(WORD_W + 1);
  localparam logic [2:0] MODE_QPSK = 3'd7;

`ifdef DDS_SEQ_IDLE_CARRIER_EN
  localparam logic IDLE_EN = 1'b1;
`else
  localparam logic IDLE_EN = 1'b0;
`endif

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t             state;
  logic [WORD_W-1:0]  sr;
  logic [WORD_W-1:0]  sr_next;
  logic [BCW-1:0]     baud_cnt;
  logic [SCW-1:0]     sym_cnt;

  // Tone modes carry no data, so they always present 00 to the DDS.
  function automatic logic [1:0] symbol_of(input logic [WORD_W-1:0] word, input logic [2:0] mode);
    logic [1:0] sym;
    case (mode)
      3'd4, 3'd5, 3'd6: sym = {1'b0, word[WORD_W-1]};
      MODE_QPSK:        sym = word[WORD_W-1 -: 2];
      default:          sym = 2'b00;
    endcase
    return sym;
  endfunction

  assign in_ready = (state == IDLE);
  assign busy     = (state == SEND);

  // Shift register advance by the bits-per-symbol of the latched mode.
  always_comb begin
    sr_next = sr;
    if (dds_mode == MODE_QPSK) begin
      sr_next = sr << 2;
    end else begin
      sr_next = sr << 1;
    end
  end

  // Main sequencer: handshake, baud timing, symbol shifting and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sr       <= '0;
      baud_cnt <= '0;
      sym_cnt  <= '0;
      dds_mode <= 3'd0;
      dds_data <= 2'b00;
      dds_en   <= IDLE_EN;
      sym_tick <= 1'b0;
      done     <= 1'b0;
    end else begin
      sym_tick <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= SEND;
            sr       <= in_word;
            dds_mode <= in_mode;
            sym_cnt  <= (in_mode == MODE_QPSK) ? SCW'(WORD_W / 2) : SCW'(WORD_W);
            baud_cnt <= '0;
            dds_data <= symbol_of(in_word, in_mode);
            dds_en   <= 1'b1;
            sym_tick <= 1'b1;
          end else begin
            dds_data <= 2'b00;
            dds_en   <= IDLE_EN;
          end
        end
        SEND: begin
          if (baud_cnt == BCW'(BAUD_DIV - 1)) begin
            baud_cnt <= '0;
            sr       <= sr_next;
            sym_cnt  <= sym_cnt - 1'b1;
            // Last symbol period just ended: drop back to idle with data cleared.
            if (sym_cnt == SCW'(1)) begin
              state    <= IDLE;
              done     <= 1'b1;
              dds_data <= 2'b00;
              dds_en   <= IDLE_EN;
            end else begin
              sym_tick <= 1'b1;
              dds_data <= symbol_of(sr_next, dds_mode);
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_symbol_sequencer.sv
// Self-checking bench for dds_symbol_sequencer with a symbol-list reference model.
module tb_dds_symbol_sequencer;
  localparam int FREQ_CLK = 8;
  localparam int BAUD     = 2;
  localparam int WORD_W   = 4;
  localparam int BD       = FREQ_CLK / BAUD;

`ifdef DDS_SEQ_IDLE_CARRIER_EN
  localparam logic IDLE_EN = 1'b1;
`else
  localparam logic IDLE_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_word;
  logic [2:0]        in_mode;
  logic [2:0]        dds_mode;
  logic [1:0]        dds_data;
  logic              dds_en;
  logic              sym_tick;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dds_symbol_sequencer #(.FREQ_CLK(FREQ_CLK), .BAUD(BAUD), .WORD_W(WORD_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_word(in_word), .in_mode(in_mode), .dds_mode(dds_mode), .dds_data(dds_data),
    .dds_en(dds_en), .sym_tick(sym_tick), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Symbol k of a payload, taken straight from the bit-numbering rules.
  function automatic logic [1:0] exp_sym(input logic [WORD_W-1:0] w, input logic [2:0] m, input int k);
    int wi;
    wi = int'(w);
    if (m < 3'd4) return 2'b00;
    if (m == 3'd7) return 2'((wi >> (WORD_W - 2 - 2 * k)) & 3);
    return 2'((wi >> (WORD_W - 1 - k)) & 1);
  endfunction

  task automatic check_idle(input string tag, input logic [2:0] m, input logic exp_done);
    chk({tag, "/busy"}, 32'(busy), 32'd0);
    chk({tag, "/ready"}, 32'(in_ready), 32'd1);
    chk({tag, "/data"}, 32'(dds_data), 32'd0);
    chk({tag, "/mode"}, 32'(dds_mode), 32'(m));
    chk({tag, "/en"}, 32'(dds_en), 32'(IDLE_EN));
    chk({tag, "/tick"}, 32'(sym_tick), 32'd0);
    chk({tag, "/done"}, 32'(done), 32'(exp_done));
  endtask

  // Offer a payload at the current cycle, check every cycle through the done cycle.
  task automatic xfer(input logic [WORD_W-1:0] w, input logic [2:0] m, input bit disturb);
    int n;
    n = (m == 3'd7) ? WORD_W / 2 : WORD_W;
    chk("ready_before", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_word  = w;
    in_mode  = m;
    step();
    for (int c = 1; c <= n * BD; c++) begin
      int k;
      k = (c - 1) / BD;
      if (disturb) begin
        in_valid = 1'b1;
        in_word  = WORD_W'($urandom);
        in_mode  = 3'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      chk("send/data", 32'(dds_data), 32'(exp_sym(w, m, k)));
      chk("send/mode", 32'(dds_mode), 32'(m));
      chk("send/busy", 32'(busy), 32'd1);
      chk("send/en", 32'(dds_en), 32'd1);
      chk("send/tick", 32'(sym_tick), 32'(((c - 1) % BD) == 0));
      chk("send/done", 32'(done), 32'd0);
      chk("send/ready", 32'(in_ready), 32'd0);
      step();
    end
    if (!disturb) in_valid = 1'b0;
    check_idle("done", m, 1'b1);
  endtask

  initial begin
    logic [2:0] last_mode;
    int gap;
    rst = 1'b1; in_valid = 1'b0; in_word = '0; in_mode = 3'd0;
    step();
    in_valid = 1'b1;
    step();
    check_idle("reset", 3'd0, 1'b0);
    rst = 1'b0; in_valid = 1'b0;
    step();
    check_idle("idle0", 3'd0, 1'b0);

    xfer(4'b1011, 3'd5, 1'b0);
    xfer(4'b1101, 3'd7, 1'b0);
    xfer(4'b1111, 3'd0, 1'b0);
    step();
    check_idle("tone_idle", 3'd0, 1'b0);

    xfer(4'b0110, 3'd6, 1'b1);
    xfer(4'b1001, 3'd4, 1'b0);
    last_mode = 3'd4;

    for (int i = 0; i < 30; i++) begin
      logic [WORD_W-1:0] w;
      logic [2:0] m;
      w = WORD_W'($urandom);
      m = 3'($urandom_range(0, 7));
      xfer(w, m, ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
      if (in_valid) begin
        w = WORD_W'($urandom);
        m = 3'($urandom_range(0, 7));
        xfer(w, m, 1'b0);
      end
      last_mode = m;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        step();
        check_idle("gap", last_mode, 1'b0);
      end
    end

    chk("rst_test/ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_word = 4'b1011; in_mode = 3'd5;
    step();
    in_valid = 1'b0;
    repeat (2 * BD + 1) step();
    chk("rst_test/busy", 32'(busy), 32'd1);
    chk("rst_test/sym2", 32'(dds_data), 32'(exp_sym(4'b1011, 3'd5, 2)));
    rst = 1'b1; in_valid = 1'b1; in_word = 4'b1111; in_mode = 3'd7;
    step();
    rst = 1'b0; in_valid = 1'b0;
    check_idle("rst_mid", 3'd0, 1'b0);
    for (int j = 0; j < 2 * BD; j++) begin
      step();
      check_idle("post_rst", 3'd0, 1'b0);
    end

    xfer(4'b0101, 3'd7, 1'b0);
    step();
    check_idle("final", 3'd7, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
